// File: rtl/mem_pkg.sv
// Shared types and default layout for the stack-aware memory controller.
package mem_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_PUSH  = 2'b10,
        OP_POP   = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SP_RD = 3'd1,
        S_XFER  = 3'd2,
        S_SP_WR = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam int SP_ADDR_DEF     = 128;
    localparam int STACK_BASE_DEF  = 129;
    localparam int STACK_DEPTH_DEF = 126;
    localparam int SPACE_ADDR      = 255;

endpackage

// File: rtl/mem_stack_ctrl.sv
// LOAD/STORE/PUSH/POP controller driving the data memory; optional STACK_GUARD_EN blocks core access to the stack region.
// Latency: Done at k+2 for LOAD/STORE and stack errors, k+4 for PUSH/POP, k+1 for guard rejects; Req is ignored while Busy.
module mem_stack_ctrl
    import mem_pkg::*;
#(
    parameter int W           = 8,
    parameter int A           = 8,
    parameter int SP_ADDR     = SP_ADDR_DEF,
    parameter int STACK_BASE  = STACK_BASE_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Req,
    input  logic [1:0]   Op,
    input  logic [A-1:0] Addr,
    input  logic [W-1:0] WrData,
    output logic         Busy,
    output logic         Done,
    output logic         Err,
    output logic [W-1:0] RdData,
    output logic [A-1:0] MemAddr,
    output logic         MemWrEn,
    output logic [W-1:0] MemWrData,
    input  logic [W-1:0] MemRdData
);

    state_t       state_q;
    op_t          op_q;
    logic [A-1:0] addr_q;
    logic [W-1:0] wdat_q;
    logic [W-1:0] sp_q;

`ifdef STACK_GUARD_EN
    localparam logic [A-1:0] GUARD_LO = A'(SP_ADDR);
    localparam logic [A-1:0] GUARD_HI = A'(STACK_BASE + STACK_DEPTH - 1);
    logic guard_hit;
    assign guard_hit = (Addr >= GUARD_LO) && (Addr <= GUARD_HI);
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_LOAD;
            addr_q  <= '0;
            wdat_q  <= '0;
            sp_q    <= '0;
            RdData  <= '0;
            Err     <= 1'b0;
            Done    <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Req) begin
                        op_q   <= op_t'(Op);
                        addr_q <= Addr;
                        wdat_q <= WrData;
                        Err    <= 1'b0;
                        Busy   <= 1'b1;
                        if (Op[1]) begin
                            state_q <= S_SP_RD;
                        end else begin
`ifdef STACK_GUARD_EN
                            if (guard_hit) begin
                                state_q <= S_FIN;
                                Err     <= 1'b1;
                                Done    <= 1'b1;
                            end else begin
                                state_q <= S_XFER;
                            end
`else
                            state_q <= S_XFER;
`endif
                        end
                    end
                end
                S_SP_RD: begin
                    sp_q <= MemRdData;
                    // Pointers beyond the depth count as full, so a corrupt SP never writes past the stack.
                    if ((op_q == OP_PUSH && MemRdData >= W'(STACK_DEPTH)) ||
                        (op_q == OP_POP  && MemRdData == '0)) begin
                        state_q <= S_FIN;
                        Err     <= 1'b1;
                        Done    <= 1'b1;
                    end else begin
                        state_q <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (op_q == OP_LOAD || op_q == OP_POP)
                        RdData <= MemRdData;
                    if (op_q == OP_PUSH || op_q == OP_POP) begin
                        state_q <= S_SP_WR;
                    end else begin
                        state_q <= S_FIN;
                        Done    <= 1'b1;
                    end
                end
                S_SP_WR: begin
                    state_q <= S_FIN;
                    Done    <= 1'b1;
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    Done    <= 1'b0;
                    Busy    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    Done    <= 1'b0;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

    // Memory port is decoded from the registered state; IDLE passes Addr through so the core can peek.
    always_comb begin
        MemAddr   = '0;
        MemWrEn   = 1'b0;
        MemWrData = '0;
        if (Reset) begin
            case (state_q)
                S_IDLE:  MemAddr = Addr;
                S_SP_RD: MemAddr = A'(SP_ADDR);
                S_XFER: begin
                    case (op_q)
                        OP_PUSH: begin
                            MemAddr   = A'(STACK_BASE) + A'(sp_q);
                            MemWrEn   = 1'b1;
                            MemWrData = wdat_q;
                        end
                        OP_POP:  MemAddr = A'(STACK_BASE) + A'(sp_q) - A'(1);
                        OP_STORE: begin
                            MemAddr   = addr_q;
                            MemWrEn   = 1'b1;
                            MemWrData = wdat_q;
                        end
                        default: MemAddr = addr_q;
                    endcase
                end
                S_SP_WR: begin
                    MemAddr   = A'(SP_ADDR);
                    MemWrEn   = 1'b1;
                    MemWrData = (op_q == OP_PUSH) ? sp_q + W'(1) : sp_q - W'(1);
                end
                default: MemAddr = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stack_ctrl.sv
// Randomized bench for mem_stack_ctrl with an attached 256x8 memory and a stack/memory-image reference model.
module tb_mem_stack_ctrl;
    import mem_pkg::*;

`ifdef STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Req;
    logic [1:0] Op;
    logic [7:0] Addr;
    logic [7:0] WrData;
    logic       Busy, Done, Err, MemWrEn;
    logic [7:0] RdData, MemAddr, MemWrData, MemRdData;

    logic [7:0] mem     [0:SPACE_ADDR] = '{default: 8'h00};
    logic [7:0] ref_mem [0:SPACE_ADDR] = '{default: 8'h00};
    logic [7:0] exp_rd = 8'h00;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    mem_stack_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Op(Op), .Addr(Addr), .WrData(WrData),
        .Busy(Busy), .Done(Done), .Err(Err), .RdData(RdData),
        .MemAddr(MemAddr), .MemWrEn(MemWrEn), .MemWrData(MemWrData), .MemRdData(MemRdData)
    );

    assign MemRdData = mem[MemAddr];
    always @(posedge Clk) if (MemWrEn) mem[MemAddr] <= MemWrData;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_mem(input string tag);
        int diffs = 0;
        for (int i = 0; i <= SPACE_ADDR; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk(tag, diffs, 0);
    endtask

    // Runs one operation, predicting latency/Err/writes/RdData from the stack rules.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] d, input bit hold);
        int sp, lat, wr_exp, n, wr;
        bit err_exp, seen;
        sp = int'(ref_mem[128]);
        err_exp = 1'b0;
        case (op)
            OP_LOAD, OP_STORE: begin
                if (GUARD && a >= 8'd128 && a <= 8'd254) begin
                    lat = 1; err_exp = 1'b1; wr_exp = 0;
                end else begin
                    lat = 2;
                    wr_exp = (op == OP_STORE) ? 1 : 0;
                    if (op == OP_STORE) ref_mem[a] = d;
                    else exp_rd = ref_mem[a];
                end
            end
            OP_PUSH: begin
                if (sp >= 126) begin
                    lat = 2; err_exp = 1'b1; wr_exp = 0;
                end else begin
                    lat = 4; wr_exp = 2;
                    ref_mem[(129 + sp) % 256] = d;
                    ref_mem[128] = 8'(sp + 1);
                end
            end
            default: begin
                if (sp == 0) begin
                    lat = 2; err_exp = 1'b1; wr_exp = 0;
                end else begin
                    lat = 4; wr_exp = 1;
                    exp_rd = ref_mem[(129 + sp - 1) % 256];
                    ref_mem[128] = 8'(sp - 1);
                end
            end
        endcase

        @(negedge Clk);
        Req = 1'b1; Op = op; Addr = a; WrData = d;
        @(posedge Clk);
        n = 0; wr = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge Clk);
            n++;
            if (n == 1) begin
                chk({tag, "_busy"}, Busy, 1);
                if (!hold) Req = 1'b0;
            end
            wr += int'(MemWrEn);
            if (Done) seen = 1'b1;
        end
        Req = 1'b0;
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_err"}, Err, err_exp);
        chk({tag, "_wr"}, wr, wr_exp);
        chk({tag, "_rd"}, RdData, exp_rd);
        @(negedge Clk);
        chk({tag, "_idle"}, {Busy, Done}, 2'b00);
        chk({tag, "_errhold"}, Err, err_exp);
        chk({tag, "_peek"}, MemRdData, ref_mem[a]);
        if (hold) begin
            repeat (2) begin
                @(negedge Clk);
                chk({tag, "_nodup"}, Done, 0);
            end
        end
        chk_mem({tag, "_mem"});
    endtask

    initial begin
        Reset = 1'b0; Req = 1'b0; Op = 2'b00; Addr = 8'h33; WrData = 8'h77;
        #12;
        chk("rst_out", {Busy, Done, Err, RdData}, 0);
        chk("rst_mem", {MemAddr, MemWrEn, MemWrData}, 0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("idle_pass", MemAddr, 8'h33);

        do_op("push41", OP_PUSH, 8'h00, 8'h41, 1'b0);
        chk("push41_m129", mem[129], 8'h41);
        chk("push41_sp", mem[128], 8'd1);
        do_op("push42", OP_PUSH, 8'h12, 8'h42, 1'b0);
        do_op("pop1", OP_POP, 8'h00, 8'h00, 1'b0);
        chk("pop1_val", RdData, 8'h42);
        do_op("pop2", OP_POP, 8'h00, 8'h00, 1'b0);
        chk("pop2_val", RdData, 8'h41);
        do_op("pop_under", OP_POP, 8'h00, 8'h00, 1'b0);
        chk("under_rd", RdData, 8'h41);
        chk("under_sp", mem[128], 8'd0);

        do_op("st5a", OP_STORE, 8'h10, 8'h5A, 1'b1);
        do_op("ld10", OP_LOAD, 8'h10, 8'h00, 1'b1);
        chk("ld10_val", RdData, 8'h5A);

        // Reset lands just after the XFER edge: the data byte is in, the SP update is not.
        begin
            @(negedge Clk);
            Req = 1'b1; Op = OP_PUSH; Addr = 8'h00; WrData = 8'hC3;
            @(posedge Clk);
            @(negedge Clk);
            Req = 1'b0;
            @(posedge Clk);
            @(posedge Clk);
            #1 Reset = 1'b0;
            #1;
            chk("abort_out", {Busy, Done, Err, RdData}, 0);
            chk("abort_mem", {MemAddr, MemWrEn, MemWrData}, 0);
            ref_mem[129 + int'(ref_mem[128])] = 8'hC3;
            exp_rd = 8'h00;
            @(negedge Clk);
            Reset = 1'b1;
            @(negedge Clk);
            chk("abort_sp", mem[128], ref_mem[128]);
            chk_mem("abort_mem_img");
        end

        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            logic [7:0] a;
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom_range(0, 255));
            if (op == OP_STORE && a == 8'd128) a = 8'd0;
            do_op("rnd", op, a, 8'($urandom), 1'($urandom_range(0, 1)));
        end

        while (ref_mem[128] < 8'd126) do_op("fill", OP_PUSH, 8'($urandom), 8'($urandom), 1'b0);
        begin
            logic [7:0] top_before;
            top_before = mem[254];
            do_op("over", OP_PUSH, 8'h00, 8'h99, 1'b0);
            chk("over_sp", mem[128], 8'd126);
            chk("over_254", mem[254], top_before);
        end

        do_op("pop_full", OP_POP, 8'h00, 8'h00, 1'b0);
        do_op("guard_st", OP_STORE, 8'd128, 8'hFF, 1'b0);
        chk("guard_sp", mem[128], GUARD ? 8'd125 : 8'hFF);
        chk("guard_err", Err, GUARD ? 1 : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
